// File: rtl/block_ram_pkg.sv
// Shared types and helpers for the byte-enable block RAM.
//   write_mode_t  : same-address read/write collision behaviour
//   clear_state_t : clear engine state encoding
//   byte_parity() : even-parity bit of one byte
//   byte_merge()  : pick the new or the old byte under a mask bit
package block_ram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } write_mode_t;

  typedef enum logic {
    CLEAR_STATE_IDLE  = 1'b0,
    CLEAR_STATE_CLEAR = 1'b1
  } clear_state_t;

  // Stored bit that makes the byte plus its parity bit carry an even number of ones.
  function automatic logic byte_parity(input logic [7:0] data_byte);
    return ^data_byte;
  endfunction

  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       mask);
    return mask ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/block_ram_clear_engine.sv
// Clear engine: sweeps every word address once, one per cycle, so the array can be zeroed
// without a reset on the storage itself.
//   clock, reset_n : system clock, asynchronous active-low reset
//   clear_request  : single-cycle pulse starting a sweep (ignored while sweeping)
//   clear_busy     : high during the sweep; the top gives the write port to the engine
//   clear_address  : word address being zeroed this cycle
module block_ram_clear_engine
  import block_ram_pkg::*;
#(
  parameter int unsigned DATA_DEPTH     = 1024,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_request,
  output logic                  clear_busy,
  output logic [ADDR_WIDTH-1:0] clear_address
);

  localparam clear_state_t RESET_STATE =
      (CLEAR_ON_RESET != 0) ? CLEAR_STATE_CLEAR : CLEAR_STATE_IDLE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDRESS = ADDR_WIDTH'(DATA_DEPTH - 1);

  clear_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      CLEAR_STATE_IDLE: begin
        if (clear_request) state_d = CLEAR_STATE_CLEAR;
      end
      CLEAR_STATE_CLEAR: begin
        if (count_q == LAST_ADDRESS) begin
          state_d = CLEAR_STATE_IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = CLEAR_STATE_IDLE;
    endcase
  end

  // Decoded straight from the state so an asserted reset shows up without a clock.
  assign clear_busy    = (state_q == CLEAR_STATE_CLEAR);
  assign clear_address = count_q;

endmodule

// File: rtl/byte_enable_block_ram.sv
// Simple dual-port block RAM (one write, one read port) with per-byte write enables,
// read latency 1 or 2, READ_FIRST / WRITE_FIRST collision mode and a clear engine.
//   clock, reset_n          : system clock, asynchronous active-low reset
//   clear_request/clear_busy: start a zeroing sweep / sweep running (accesses ignored)
//   write_enable, write_byte_enable, write_address, write_data : write port
//   read_enable, read_address : read port
//   read_data, read_data_valid : read result and its one-cycle qualifier
//   read_parity_error       : per-byte parity mismatch (only with BLOCK_RAM_PARITY_EN)
// Optional feature macro: BLOCK_RAM_PARITY_EN adds a stored even-parity bit per byte.
module byte_enable_block_ram
  import block_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DATA_DEPTH     = 1024,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          clear_request,
  output logic                          clear_busy,
  input  logic                          write_enable,
  input  logic [DATA_WIDTH/8-1:0]       write_byte_enable,
  input  logic [$clog2(DATA_DEPTH)-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]         write_data,
  input  logic                          read_enable,
  input  logic [$clog2(DATA_DEPTH)-1:0] read_address,
  output logic [DATA_WIDTH-1:0]         read_data,
  output logic                          read_data_valid
`ifdef BLOCK_RAM_PARITY_EN
  ,
  output logic [DATA_WIDTH/8-1:0]       read_parity_error
`endif
);

  localparam int unsigned NUM_BYTES  = DATA_WIDTH / 8;
  localparam int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam bit          WRITE_FIRST_MODE = (WRITE_MODE == 32'(WRITE_FIRST));

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
`ifdef BLOCK_RAM_PARITY_EN
  logic [NUM_BYTES-1:0]  par_mem [DATA_DEPTH];
`endif

  logic [ADDR_WIDTH-1:0] clear_address;

  block_ram_clear_engine #(
    .DATA_DEPTH     (DATA_DEPTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_engine (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear_request (clear_request),
    .clear_busy    (clear_busy),
    .clear_address (clear_address)
  );

  logic write_accept, read_accept, read_in_range, collide;

  assign write_accept  = write_enable && !clear_busy && (32'(write_address) < DATA_DEPTH);
  assign read_accept   = read_enable && !clear_busy;
  assign read_in_range = (32'(read_address) < DATA_DEPTH);
  assign collide       = WRITE_FIRST_MODE && write_accept && (write_address == read_address);

  // Single physical write port: the clear engine owns it for the whole sweep.
  logic                  port_write;
  logic [ADDR_WIDTH-1:0] port_address;
  logic [DATA_WIDTH-1:0] port_data;
  logic [NUM_BYTES-1:0]  port_mask;

  always_comb begin
    port_write   = 1'b0;
    port_address = write_address;
    port_data    = write_data;
    port_mask    = write_byte_enable;
    if (clear_busy) begin
      port_write   = 1'b1;
      port_address = clear_address;
      port_data    = '0;
      port_mask    = '1;
    end else if (write_accept) begin
      port_write   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (port_write) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (port_mask[k]) begin
          mem[port_address][8*k +: 8] <= port_data[8*k +: 8];
`ifdef BLOCK_RAM_PARITY_EN
          par_mem[port_address][k]    <= byte_parity(port_data[8*k +: 8]);
`endif
        end
      end
    end
  end

  // Array read; in WRITE_FIRST mode the enabled bytes of a colliding write bypass the array.
  logic [DATA_WIDTH-1:0] read_word;
`ifdef BLOCK_RAM_PARITY_EN
  logic [NUM_BYTES-1:0]  read_par, read_err;
`endif

  always_comb begin
    read_word = '0;
`ifdef BLOCK_RAM_PARITY_EN
    read_par  = '0;
    read_err  = '0;
`endif
    if (read_in_range) begin
      read_word = mem[read_address];
`ifdef BLOCK_RAM_PARITY_EN
      read_par  = par_mem[read_address];
`endif
    end
    if (collide) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        read_word[8*k +: 8] = byte_merge(read_word[8*k +: 8], write_data[8*k +: 8],
                                         write_byte_enable[k]);
`ifdef BLOCK_RAM_PARITY_EN
        if (write_byte_enable[k]) read_par[k] = byte_parity(write_data[8*k +: 8]);
`endif
      end
    end
`ifdef BLOCK_RAM_PARITY_EN
    for (int k = 0; k < NUM_BYTES; k++) begin
      read_err[k] = byte_parity(read_word[8*k +: 8]) ^ read_par[k];
    end
`endif
  end

  // Stage 1: the data register holds its value until the next accepted read.
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_valid_q;
`ifdef BLOCK_RAM_PARITY_EN
  logic [NUM_BYTES-1:0]  s1_err_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
`ifdef BLOCK_RAM_PARITY_EN
      s1_err_q   <= '0;
`endif
    end else begin
      s1_valid_q <= read_accept;
      if (read_accept) s1_data_q <= read_word;
`ifdef BLOCK_RAM_PARITY_EN
      s1_err_q   <= read_accept ? read_err : '0;
`endif
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_latency_2
      logic [DATA_WIDTH-1:0] out_data_q;
      logic                  out_valid_q;
`ifdef BLOCK_RAM_PARITY_EN
      logic [NUM_BYTES-1:0]  out_err_q;
`endif
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
`ifdef BLOCK_RAM_PARITY_EN
          out_err_q   <= '0;
`endif
        end else begin
          out_valid_q <= s1_valid_q;
          if (s1_valid_q) out_data_q <= s1_data_q;
`ifdef BLOCK_RAM_PARITY_EN
          out_err_q   <= s1_valid_q ? s1_err_q : '0;
`endif
        end
      end
      assign read_data         = out_data_q;
      assign read_data_valid   = out_valid_q;
`ifdef BLOCK_RAM_PARITY_EN
      assign read_parity_error = out_err_q;
`endif
    end else begin : g_latency_1
      assign read_data         = s1_data_q;
      assign read_data_valid   = s1_valid_q;
`ifdef BLOCK_RAM_PARITY_EN
      assign read_parity_error = s1_err_q;
`endif
    end
  endgenerate

endmodule
